// File: rtl/bird_frame_ctrl.sv
// Game controller for a single-sprite flapping bird: frame tick detection, bird physics,
// IDLE/PLAY/DEAD sequencing, score keeping and sprite pixel hit for the VGA pipeline.
module bird_frame_ctrl #(
    parameter int BIRD_X    = 300,
    parameter int BIRD_SIZE = 16,
    parameter int TOP_Y     = 35,
    parameter int FLOOR_Y   = 499,
    parameter int START_Y   = 240,
    parameter int FLAP_VEL  = -8,
    parameter int GRAVITY   = 1,
    parameter int VMAX      = 10,
    parameter int DEAD_HOLD = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       bright,
    input  logic       flap_btn,
    input  logic       collide,
    input  logic       pipe_pass,
    output logic       frame_tick,
    output logic [1:0] state,
    output logic [9:0] bird_y,
    output logic [7:0] score,
    output logic       bird_on
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StDead = 2'd2
    } state_e;

    localparam logic signed [10:0] TopY     = 11'(TOP_Y);
    localparam logic signed [10:0] FloorY   = 11'(FLOOR_Y);
    localparam logic [9:0]         StartY   = 10'(START_Y);
    localparam logic signed [7:0]  FlapVel  = 8'(FLAP_VEL);
    localparam logic signed [7:0]  Gravity  = 8'(GRAVITY);
    localparam logic signed [7:0]  Vmax     = 8'(VMAX);
    localparam logic [7:0]         DeadHold = 8'(DEAD_HOLD);
    localparam logic [10:0]        BirdXL   = 11'(BIRD_X);
    localparam logic [10:0]        BirdSize = 11'(BIRD_SIZE);

    state_e state_q, state_d;

    logic             sync1_q, sync2_q, sync_prev_q;
    logic             flap_pend_q;
    logic             match_prev_q, tick_q;
    logic             line_match;
    logic [9:0]       bird_y_q, bird_y_d;
    logic signed [7:0] vel_q, vel_d;
    logic [7:0]       score_q, score_d;
    logic [7:0]       dead_cnt_q, dead_cnt_d;
    logic             bird_on_q, bird_on_d;

    logic signed [10:0] ny;
    logic signed [8:0]  vel_grav;
    logic signed [7:0]  vel_fall;
    logic [9:0]         y_clamped;
    logic               hit_bound;
    logic               restart;

    // Counts hold for several clks per pixel; only the first clk of the match yields a tick.
    assign line_match = (vCount == 10'd516) && (hCount == 10'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync_prev_q  <= 1'b0;
            flap_pend_q  <= 1'b0;
            match_prev_q <= 1'b1;
            tick_q       <= 1'b0;
        end else begin
            sync1_q      <= flap_btn;
            sync2_q      <= sync1_q;
            sync_prev_q  <= sync2_q;
            flap_pend_q  <= (flap_pend_q & ~tick_q) | (sync2_q & ~sync_prev_q);
            match_prev_q <= line_match;
            tick_q       <= line_match & ~match_prev_q;
        end
    end

    // Physics helpers shared by PLAY and DEAD.
    always_comb begin
        ny       = $signed({1'b0, bird_y_q}) + 11'(vel_q);
        vel_grav = 9'(vel_q) + 9'(Gravity);
        vel_fall = (vel_grav > 9'(Vmax)) ? Vmax : vel_grav[7:0];
        if (ny < TopY) begin
            y_clamped = TopY[9:0];
        end else if (ny > FloorY) begin
            y_clamped = FloorY[9:0];
        end else begin
            y_clamped = ny[9:0];
        end
        hit_bound = (ny <= TopY) || (ny >= FloorY);
        restart   = tick_q && flap_pend_q && (dead_cnt_q == DeadHold);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (tick_q && flap_pend_q) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (collide || (tick_q && hit_bound)) begin
                    state_d = StDead;
                end
            end
            StDead: begin
                if (restart) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        state = state_q;
    end

    always_comb begin
        bird_y_d   = bird_y_q;
        vel_d      = vel_q;
        score_d    = score_q;
        dead_cnt_d = dead_cnt_q;
        case (state_q)
            StIdle: begin
                bird_y_d = StartY;
                vel_d    = '0;
                if (tick_q && flap_pend_q) begin
                    vel_d   = FlapVel;
                    score_d = '0;
                end
            end
            StPlay: begin
                if (pipe_pass && (score_q != 8'hff)) begin
                    score_d = score_q + 8'd1;
                end
                // A collide freezes the bird where it is; the physics of this tick is dropped.
                if (tick_q && !collide) begin
                    bird_y_d = y_clamped;
                    vel_d    = flap_pend_q ? FlapVel : vel_fall;
                end
            end
            StDead: begin
                if (tick_q) begin
                    if (restart) begin
                        bird_y_d = StartY;
                        vel_d    = '0;
                    end else begin
                        bird_y_d = y_clamped;
                        vel_d    = vel_fall;
                    end
                    if (dead_cnt_q != DeadHold) begin
                        dead_cnt_d = dead_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                bird_y_d = StartY;
                vel_d    = '0;
            end
        endcase
        // Zero outside DEAD so every entry into DEAD starts the hold count afresh.
        if (state_q != StDead) begin
            dead_cnt_d = '0;
        end
    end

    always_comb begin
        bird_on_d = bright
                 && ({1'b0, hCount} >= BirdXL)
                 && ({1'b0, hCount} < BirdXL + BirdSize)
                 && ({1'b0, vCount} >= {1'b0, bird_y_q})
                 && ({1'b0, vCount} < {1'b0, bird_y_q} + BirdSize);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bird_y_q   <= StartY;
            vel_q      <= '0;
            score_q    <= '0;
            dead_cnt_q <= '0;
            bird_on_q  <= 1'b0;
        end else begin
            bird_y_q   <= bird_y_d;
            vel_q      <= vel_d;
            score_q    <= score_d;
            dead_cnt_q <= dead_cnt_d;
            bird_on_q  <= bird_on_d;
        end
    end

    assign frame_tick = tick_q;
    assign bird_y     = bird_y_q;
    assign score      = score_q;
    assign bird_on    = bird_on_q;

endmodule

// File: tb/tb_bird_frame_ctrl.sv
// Directed bench for bird_frame_ctrl: tick generation, arc, collide, restart hold,
// floor death, score saturation, sprite hit window and mid-game reset.
module tb_bird_frame_ctrl;

    logic       clk;
    logic       rst;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       bright;
    logic       flap_btn;
    logic       collide;
    logic       pipe_pass;
    logic       frame_tick;
    logic [1:0] state;
    logic [9:0] bird_y;
    logic [7:0] score;
    logic       bird_on;

    int n_checks = 0;
    int n_errors = 0;
    int tick_seen = 0;
    int tick_bad = 0;

    bird_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .hCount     (hCount),
        .vCount     (vCount),
        .bright     (bright),
        .flap_btn   (flap_btn),
        .collide    (collide),
        .pipe_pass  (pipe_pass),
        .frame_tick (frame_tick),
        .state      (state),
        .bird_y     (bird_y),
        .score      (score),
        .bird_on    (bird_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_tick === 1'b1) begin
            tick_seen++;
            if (!(vCount == 10'd516 && hCount == 10'd0)) tick_bad++;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One abbreviated frame: leave line 516, then hold (516,0) for one pixel (4 clks).
    task automatic run_frame();
        @(negedge clk);
        vCount = 10'd100;
        hCount = 10'd7;
        repeat (2) @(negedge clk);
        vCount = 10'd516;
        hCount = 10'd0;
        repeat (4) @(negedge clk);
        hCount = 10'd1;
        @(negedge clk);
    endtask

    task automatic press_flap();
        @(negedge clk);
        flap_btn = 1'b1;
        repeat (4) @(negedge clk);
        flap_btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_pass();
        @(negedge clk);
        pipe_pass = 1'b1;
        @(negedge clk);
        pipe_pass = 1'b0;
    endtask

    int arc_exp [3] = '{232, 225, 219};
    int bo_h    [7] = '{300, 315, 316, 299, 300, 300, 305};
    int bo_v    [7] = '{240, 255, 240, 240, 256, 239, 245};
    int bo_b    [7] = '{1, 1, 1, 1, 1, 1, 0};
    int bo_exp  [7] = '{1, 1, 0, 0, 0, 0, 0};
    int t0;

    initial begin
        rst       = 1'b1;
        hCount    = 10'd0;
        vCount    = 10'd516;
        bright    = 1'b0;
        flap_btn  = 1'b0;
        collide   = 1'b0;
        pipe_pass = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state; counts already at line 516 must not tick.
        check_eq("reset_no_tick", tick_seen, 0);
        check_eq("reset_state", int'(state), 0);
        check_eq("reset_bird_y", int'(bird_y), 240);
        check_eq("reset_score", int'(score), 0);
        check_eq("reset_bird_on", int'(bird_on), 0);

        // Three compressed frames of counts, 4 clks per pixel.
        tick_seen = 0;
        for (int f = 0; f < 3; f++) begin
            for (int v = 514; v <= 518; v++) begin
                for (int h = 0; h < 4; h++) begin
                    @(negedge clk);
                    vCount = 10'(v);
                    hCount = 10'(h);
                    repeat (3) @(negedge clk);
                end
            end
            @(negedge clk);
            vCount = 10'd0;
            hCount = 10'd0;
        end
        repeat (2) @(negedge clk);
        check_eq("tick_count", tick_seen, 3);
        check_eq("tick_position", tick_bad, 0);
        check_eq("idle_no_start", int'(state), 0);

        // Sprite window around (300,240) with 1-clk latency.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            hCount = 10'(bo_h[i]);
            vCount = 10'(bo_v[i]);
            bright = bo_b[i][0];
            @(negedge clk);
            check_eq($sformatf("bird_on_%0d", i), int'(bird_on), bo_exp[i]);
        end
        bright = 1'b0;

        // Start and arc.
        press_flap();
        run_frame();
        check_eq("start_state", int'(state), 1);
        check_eq("start_bird_y", int'(bird_y), 240);
        repeat (3) pulse_pass();
        for (int i = 0; i < 3; i++) begin
            run_frame();
            check_eq($sformatf("arc_y_%0d", i), int'(bird_y), arc_exp[i]);
        end
        check_eq("arc_state", int'(state), 1);
        check_eq("play_score", int'(score), 3);

        // Collide with a pending flap: DEAD one clk later, flap has no effect (y 219 v -5).
        press_flap();
        @(negedge clk);
        collide = 1'b1;
        @(negedge clk);
        collide = 1'b0;
        check_eq("collide_dead", int'(state), 2);
        run_frame();
        check_eq("collide_y1", int'(bird_y), 214);
        run_frame();
        check_eq("collide_y2", int'(bird_y), 210);

        // Restart hold: 2 DEAD ticks done so far.
        repeat (27) run_frame();
        press_flap();
        run_frame();
        check_eq("hold_tick30", int'(state), 2);
        repeat (29) run_frame();
        press_flap();
        run_frame();
        check_eq("hold_tick60", int'(state), 2);
        check_eq("dead_floor_y", int'(bird_y), 499);
        check_eq("dead_score", int'(score), 3);
        press_flap();
        run_frame();
        check_eq("restart_state", int'(state), 0);
        check_eq("restart_bird_y", int'(bird_y), 240);
        check_eq("restart_score_kept", int'(score), 3);
        pulse_pass();
        check_eq("idle_pass_ignored", int'(score), 3);

        // New game: score clears, then saturates.
        press_flap();
        run_frame();
        check_eq("start2_state", int'(state), 1);
        check_eq("start2_score", int'(score), 0);
        repeat (300) pulse_pass();
        check_eq("score_sat", int'(score), 255);

        // Floor death without flaps: tick 42 -> 489 PLAY, tick 43 -> 499 DEAD.
        repeat (41) run_frame();
        run_frame();
        check_eq("fall_state_42", int'(state), 1);
        check_eq("fall_y_42", int'(bird_y), 489);
        run_frame();
        check_eq("floor_state", int'(state), 2);
        check_eq("floor_y", int'(bird_y), 499);
        run_frame();
        check_eq("floor_hold_y", int'(bird_y), 499);
        pulse_pass();
        check_eq("dead_pass_ignored", int'(score), 255);

        // Mid-game reset while the sprite is lit and counts sit at line 516.
        @(negedge clk);
        hCount = 10'd300;
        vCount = 10'd500;
        bright = 1'b1;
        @(negedge clk);
        check_eq("pre_rst_bird_on", int'(bird_on), 1);
        rst    = 1'b1;
        hCount = 10'd0;
        vCount = 10'd516;
        t0     = tick_seen;
        @(negedge clk);
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_bird_y", int'(bird_y), 240);
        check_eq("rst_score", int'(score), 0);
        check_eq("rst_bird_on", int'(bird_on), 0);
        check_eq("rst_frame_tick", int'(frame_tick), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_no_stale_tick", tick_seen, t0);
        run_frame();
        check_eq("rst_fresh_tick", tick_seen, t0 + 1);
        check_eq("rst_idle_after_tick", int'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bird_frame_ctrl.md
BIRD_FRAME_CTRL -- requirements
Module: bird_frame_ctrl

Parameters
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- BIRD_X, 300, fixed left column of the bird sprite.
- BIRD_SIZE, 16, sprite edge in pixels.
- TOP_Y, 35, first visible line.
- FLOOR_Y, 499, lowest legal bird_y (515 - BIRD_SIZE).
- START_Y, 240, bird_y in IDLE.
- FLAP_VEL, -8, velocity loaded on a flap (signed).
- GRAVITY, 1, velocity increment per frame.
- VMAX, 10, terminal downward velocity.
- DEAD_HOLD, 60, frames before a restart is accepted.

Interface
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, 100 MHz system clock, the only clock.
- rst, in, 1, synchronous, active-high reset.
- hCount, in, 10, pixel column from the VGA timing generator.
- vCount, in, 10, line number from the VGA timing generator.
- bright, in, 1, visible-area flag.
- flap_btn, in, 1, raw asynchronous button.
- collide, in, 1, one-cycle pulse on pipe overlap.
- pipe_pass, in, 1, one-cycle pulse when a pipe clears the bird.
- frame_tick, out, 1, one-cycle pulse at frame update.
- state, out, 2, game state: 0 IDLE, 1 PLAY, 2 DEAD.
- bird_y, out, 10, bird top line.
- score, out, 8, pipes passed.
- bird_on, out, 1, current pixel lies inside the bird.

Function
REQ-003 flap_btn SHALL pass through a 2-FF synchronizer. The rising edge of the synchronized signal SHALL set flap_pend.
REQ-004 frame_tick SHALL pulse for exactly one clk when (vCount==516 && hCount==0) becomes true, i.e. current true and previous false. This gives one tick per frame even though the counts hold for 4 clks.
REQ-005 All physics updates SHALL occur only on clks where frame_tick is high. flap_pend SHALL clear on every frame_tick, whether consumed or discarded.
REQ-006 IDLE behaviour:
- bird_y = START_Y and vel = 0.
- On a tick with flap_pend: go to PLAY, set vel = FLAP_VEL, clear score. bird_y stays unchanged on that tick.
REQ-007 PLAY behaviour, on each tick:
- ny = bird_y + vel, computed as a signed 11-bit value.
- bird_y = clamp(ny, TOP_Y, FLOOR_Y).
- Then vel = FLAP_VEL if flap_pend, else min(vel + GRAVITY, VMAX).
REQ-008 In PLAY, if ny <= TOP_Y or ny >= FLOOR_Y, state SHALL become DEAD on the same tick.
REQ-009 In PLAY, a collide pulse on any clk SHALL move state to DEAD on the next clk. The kill SHALL NOT wait for a tick.
REQ-010 collide and a flap on the same tick: DEAD SHALL win.
REQ-011 On entry to DEAD, dead_cnt SHALL be set to 0.
REQ-012 DEAD behaviour, on each tick:
- Apply gravity with flap ignored; bird_y clamps at FLOOR_Y.
- dead_cnt increments, saturating at DEAD_HOLD.
- If dead_cnt == DEAD_HOLD (value before increment) and flap_pend, go to IDLE.
REQ-013 pipe_pass in PLAY SHALL increment score, saturating at 255. pipe_pass SHALL be ignored in IDLE and DEAD, and score SHALL hold in those states.
REQ-014 vel SHALL be a signed 8-bit register. With the default parameters it never exceeds the range [-8, 10].
REQ-015 bird_on SHALL be registered with a 1-clk latency. It SHALL be 1 when all of these hold: bright, BIRD_X <= hCount < BIRD_X+BIRD_SIZE, and bird_y <= vCount < bird_y+BIRD_SIZE.
REQ-016 state SHALL never take the value 3. An illegal state SHALL recover to IDLE on the next clk.

Reset
REQ-017 While rst is high on a rising clk edge, the block SHALL take these values:
- state = IDLE, bird_y = START_Y, vel = 0, score = 0.
- dead_cnt = 0, flap_pend = 0, synchronizer flops = 0.
- bird_on = 0, frame_tick = 0.
- Previous-match flag = 1, so no tick is produced for a frame already at line 516.
REQ-018 A reset asserted mid-frame or mid-game SHALL abandon all state. The first tick after reset SHALL occur only at the next fresh line-516 transition.

Verification
REQ-019 Tick generation: run 3 frames of counts (4 clks per pixel) -> exactly 3 frame_tick pulses, one clk each, at hCount=0 vCount=516.
REQ-020 Start and arc:
- Stimulus: from IDLE, one flap before tick 0.
- Tick 0: state=PLAY, bird_y=240.
- Then bird_y follows 232, 225, 219, ... (vel -8, -7, -6, ...).
REQ-021 Floor death: PLAY with no flaps -> bird_y reaches 499 and state=DEAD on that tick; bird_y holds at 499 afterwards.
REQ-022 Collide plus flap: collide pulse in the same frame as a flap -> DEAD one clk after collide; the flap has no effect.
REQ-023 Restart hold:
- A flap at DEAD frame 30 is ignored.
- A flap before frame 61 -> IDLE, bird_y=240; score is kept until the next start.
REQ-024 Score: 300 pipe_pass pulses in PLAY -> score=255. pipe_pass in IDLE -> unchanged. rst mid-frame -> all outputs at their reset values on the next clk.
